// File: rtl/load_store_unit.sv
// Memory-stage initiator: turns LDR/STR/LDRB/STRB into data_memory strobes and formats load results.
// Optional macro LSU_ALIGN_ABORT_EN makes unaligned word accesses abort instead of align/rotate.
module load_store_unit #(
  parameter int ADDR_WIDTH       = 32,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_rd,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [3:0]            resp_rd,
  output logic                  resp_abort,
  output logic                  write_word_en,
  output logic                  write_byte_en,
  output logic                  read_word_en,
  output logic                  read_byte_en,
  output logic [ADDR_WIDTH-1:0] write_word_address,
  output logic [ADDR_WIDTH-1:0] write_byte_address,
  output logic [ADDR_WIDTH-1:0] read_word_address,
  output logic [ADDR_WIDTH-1:0] read_byte_address,
  output logic [31:0]           write_word_data,
  output logic [7:0]            write_byte_data,
  input  logic [31:0]           read_word_data,
  input  logic [7:0]            read_byte_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_READ_LATENCY - 1);

  state_t                state, state_nxt;
  logic                  accept;
  logic                  abort_req;
  logic                  wait_done;
  logic [2:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_rd;
  logic                  lat_byte;

  // ARM7 unaligned LDR: the addressed byte ends up in bits [7:0]
  function automatic logic [31:0] ror_bytes(input logic [31:0] w, input logic [1:0] sh);
    case (sh)
      2'd1:    ror_bytes = {w[7:0],  w[31:8]};
      2'd2:    ror_bytes = {w[15:0], w[31:16]};
      2'd3:    ror_bytes = {w[23:0], w[31:24]};
      default: ror_bytes = w;
    endcase
  endfunction

  assign req_ready    = rst_n && (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign wait_done    = (state == WAIT) && (wait_cnt == WAIT_LAST);
  assign aligned_addr = {lat_addr[ADDR_WIDTH-1:2], 2'b00};

  assign write_word_address = aligned_addr;
  assign read_word_address  = aligned_addr;
  assign write_byte_address = lat_addr;
  assign read_byte_address  = lat_addr;
  assign write_word_data    = lat_wdata;
  assign write_byte_data    = lat_wdata[7:0];

`ifdef LSU_ALIGN_ABORT_EN
  assign abort_req = !req_byte && (req_address[1:0] != 2'b00);

  // High only for the RESP cycle entered straight from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_abort <= 1'b0;
    else        resp_abort <= accept && abort_req;
  end
`else
  assign abort_req  = 1'b0;
  assign resp_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (abort_req)      state_nxt = RESP;
          else if (req_write) state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the accepted request so they coincide with WRITE/READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_word_en <= 1'b0;
      write_byte_en <= 1'b0;
      read_word_en  <= 1'b0;
      read_byte_en  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_rd       <= '0;
      wait_cnt      <= '0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_rd        <= '0;
      lat_byte      <= 1'b0;
    end else begin
      write_word_en <= accept && !abort_req &&  req_write && !req_byte;
      write_byte_en <= accept && !abort_req &&  req_write &&  req_byte;
      read_word_en  <= accept && !abort_req && !req_write && !req_byte;
      read_byte_en  <= accept && !abort_req && !req_write &&  req_byte;
      resp_valid    <= (state_nxt == RESP);
      wait_cnt      <= ((state == WAIT) && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
      if (accept) begin
        lat_addr  <= req_address;
        lat_wdata <= req_wdata;
        lat_rd    <= req_rd;
        lat_byte  <= req_byte;
      end
      if (wait_done) begin
        resp_rdata <= lat_byte ? {24'b0, read_byte_data} : ror_bytes(read_word_data, lat_addr[1:0]);
        resp_rd    <= lat_rd;
      end else if (accept && abort_req) begin
        resp_rdata <= '0;
        resp_rd    <= req_rd;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data_memory stand-in plus an independent byte-level reference memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [31:0] req_address, req_wdata;
  logic [3:0]  req_rd;
  logic        resp_valid, resp_abort;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_rd;
  logic        write_word_en, write_byte_en, read_word_en, read_byte_en;
  logic [31:0] write_word_address, write_byte_address, read_word_address, read_byte_address;
  logic [31:0] write_word_data, read_word_data;
  logic [7:0]  write_byte_data, read_byte_data;
  logic [3:0]  strobes;

  logic [7:0]  dmem    [0:8191];
  logic [7:0]  ref_mem [0:8191];

  int n_chk = 0, n_err = 0;
  int n_resp_seen = 0, n_resp_exp = 0;
  int n_acc_seen = 0, n_acc_exp = 0;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
    .req_address(req_address), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_abort(resp_abort),
    .write_word_en(write_word_en), .write_byte_en(write_byte_en),
    .read_word_en(read_word_en), .read_byte_en(read_byte_en),
    .write_word_address(write_word_address), .write_byte_address(write_byte_address),
    .read_word_address(read_word_address), .read_byte_address(read_byte_address),
    .write_word_data(write_word_data), .write_byte_data(write_byte_data),
    .read_word_data(read_word_data), .read_byte_data(read_byte_data)
  );

  always #5 clk = ~clk;

  assign strobes = {write_word_en, write_byte_en, read_word_en, read_byte_en};

  // Synchronous data_memory stand-in: read data valid after the sampling edge
  always @(posedge clk) begin
    if (write_word_en) begin
      dmem[write_word_address[12:0]]         <= write_word_data[7:0];
      dmem[write_word_address[12:0] + 13'd1] <= write_word_data[15:8];
      dmem[write_word_address[12:0] + 13'd2] <= write_word_data[23:16];
      dmem[write_word_address[12:0] + 13'd3] <= write_word_data[31:24];
    end
    if (write_byte_en) dmem[write_byte_address[12:0]] <= write_byte_data;
    if (read_word_en)
      read_word_data <= {dmem[read_word_address[12:0] + 13'd3], dmem[read_word_address[12:0] + 13'd2],
                         dmem[read_word_address[12:0] + 13'd1], dmem[read_word_address[12:0]]};
    if (read_byte_en) read_byte_data <= dmem[read_byte_address[12:0]];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_val("strobe_excl", 64'($countones(strobes) <= 1), 64'd1);
    if (resp_valid) n_resp_seen++;
    if (rst_n && req_valid && req_ready) n_acc_seen++;
  end

  // Reference load: result byte i is memory byte (offset+i) mod 4 of the addressed word
  function automatic logic [31:0] model_load(input bit b, input logic [31:0] a);
    logic [31:0] r;
    int base, k;
    r = '0;
    if (b) begin
      r[7:0] = ref_mem[int'(a[12:0])];
    end else begin
      base = int'(a[12:0]) & ~3;
      k    = int'(a[1:0]);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[base + ((i + k) % 4)];
    end
    return r;
  endfunction

  // Presents a request and returns 1 time unit after the accepting edge
  task automatic issue(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input bit keep);
    int n;
    req_valid = 1'b1; req_write = w; req_byte = b; req_address = a; req_wdata = d; req_rd = rd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_timeout", 64'(n < 20), 64'd1);
    n_acc_exp++;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge
  task automatic expect_txn(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] rd);
    logic [31:0] aw, exp_data;
    bit ab;
    aw = {a[31:2], 2'b00};
    ab = 1'b0;
`ifdef LSU_ALIGN_ABORT_EN
    ab = !b && (a[1:0] != 2'b00);
`endif
    if (ab) begin
      n_resp_exp++;
      check_val("abort_strobe", strobes, 0);
      check_val("abort_valid", resp_valid, 1);
      check_val("abort_flag", resp_abort, 1);
      check_val("abort_rdata", resp_rdata, 0);
      check_val("abort_rd", resp_rd, rd);
      @(posedge clk); #1;
      check_val("abort_done", {resp_valid, req_ready}, 2'b01);
    end else if (w) begin
      check_val("st_strobe", strobes, b ? 4'b0100 : 4'b1000);
      check_val("st_busy", req_ready, 0);
      if (b) begin
        check_val("st_baddr", write_byte_address, a);
        check_val("st_bdata", write_byte_data, d[7:0]);
        ref_mem[int'(a[12:0])] = d[7:0];
      end else begin
        check_val("st_waddr", write_word_address, aw);
        check_val("st_wdata", write_word_data, d);
        for (int i = 0; i < 4; i++) ref_mem[int'(aw[12:0]) + i] = d[8*i +: 8];
      end
      @(posedge clk); #1;
      check_val("st_done", {strobes, resp_valid, req_ready}, 6'b000001);
    end else begin
      n_resp_exp++;
      exp_data = model_load(b, a);
      check_val("ld_strobe", strobes, b ? 4'b0001 : 4'b0010);
      check_val("ld_addr", b ? read_byte_address : read_word_address, b ? a : aw);
      check_val("ld_busy", {resp_valid, req_ready}, 2'b00);
      @(posedge clk); #1;
      check_val("ld_wait", {strobes, resp_valid, req_ready}, 6'b000000);
      @(posedge clk); #1;
      check_val("ld_valid", resp_valid, 1);
      check_val("ld_rdata", resp_rdata, exp_data);
      check_val("ld_rd", resp_rd, rd);
      check_val("ld_abort", resp_abort, 0);
      @(posedge clk); #1;
      check_val("ld_done", {resp_valid, req_ready}, 2'b01);
      check_val("ld_hold", resp_rdata, exp_data);
    end
  endtask

  task automatic txn(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d, input logic [3:0] rd);
    issue(w, b, a, d, rd, 1'b0);
    expect_txn(w, b, a, d, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      dmem[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
    read_word_data = '0; read_byte_data = '0;
    req_valid = 0; req_write = 0; req_byte = 0; req_address = '0; req_wdata = '0; req_rd = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_val("rst_ready", req_ready, 0);
    check_val("rst_strobes", strobes, 0);
    check_val("rst_resp", {resp_valid, resp_abort, resp_rdata, resp_rd}, 0);
    check_val("rst_addrs", {write_word_address, write_byte_address, read_word_address, read_byte_address}, 0);
    check_val("rst_wdata", {write_word_data, write_byte_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("idle_ready", req_ready, 1);

    txn(1, 0, 32'h1000, 32'hDEADBEEF, 4'd0);
    txn(0, 0, 32'h1000, 32'h0, 4'd5);
    check_val("tp_word", resp_rdata, 32'hDEADBEEF);
    check_val("tp_tag", resp_rd, 4'd5);
    txn(1, 1, 32'h1001, 32'h000000AA, 4'd0);
    txn(0, 0, 32'h1000, 32'h0, 4'd1);
    check_val("tp_merge", resp_rdata, 32'hDEADAAEF);
    txn(0, 1, 32'h1003, 32'h0, 4'd2);
    check_val("tp_byte3", resp_rdata, 32'h000000DE);
    txn(0, 1, 32'h1001, 32'h0, 4'd3);
    check_val("tp_byte1", resp_rdata, 32'h000000AA);
    txn(0, 0, 32'h1001, 32'h0, 4'd4);
`ifdef LSU_ALIGN_ABORT_EN
    check_val("tp_unaligned", resp_rdata, 32'h0);
`else
    check_val("tp_unaligned", resp_rdata, 32'hEFDEADAA);
`endif

    // req_valid held high across a store followed by a load
    issue(1, 0, 32'h1004, 32'h12345678, 4'd0, 1'b1);
    req_write = 1'b0; req_address = 32'h1004; req_rd = 4'd7;
    expect_txn(1, 0, 32'h1004, 32'h12345678, 4'd0);
    n_acc_exp++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_txn(0, 0, 32'h1004, 32'h0, 4'd7);
    check_val("b2b_data", resp_rdata, 32'h12345678);

    // Reset while a load is in WAIT
    issue(0, 0, 32'h1000, 32'h0, 4'd9, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_strobes", strobes, 0);
    check_val("midrst_resp", {resp_valid, resp_rdata, resp_rd}, 0);
    check_val("midrst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("midrst_no_resp", n_resp_seen, n_resp_exp);
    @(posedge clk); #1;
    txn(0, 0, 32'h1000, 32'h0, 4'd6);
    check_val("midrst_reload", resp_rdata, 32'hDEADAAEF);

    for (int t = 0; t < 60; t++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31)),
          $urandom, 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk); #1;
    check_val("resp_count", n_resp_seen, n_resp_exp);
    check_val("accept_count", n_acc_seen, n_acc_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
